id_stage_param: RTL and testbench

Parametrised instruction-decode stage with an ID/EX pipeline register. It decodes register fields and immediates, reads an internal reset-able register file, and applies the forwarding mux. It also generates branch compare flags, branch/jump targets and the return address. It is the successor to the fixed 16-bit decode stage and adds valid tracking, stall/flush handling, a hardwired zero register, write-through bypass and selectable signed/unsigned compare. It sits between IF/ID and EX; the hazard unit drives stall, flush and the forward selects.

---
 rtl/id_pkg.sv | 29 ++
 rtl/id_regfile.sv | 54 +++++
 rtl/id_stage_param.sv | 158 +++++++++++++++
 tb/tb_id_stage_param.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared constants for the decode stage: forward-select codes, ctrl bit positions
// and helpers that locate the register fields inside an instruction word.
package id_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_ALU = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam int CTRL_EXT_PLACE   = 0;
    localparam int CTRL_EXT_OP      = 1;
    localparam int CTRL_REGDST_LINK = 2;
    localparam int CTRL_SRC2_SEL    = 3;
    localparam int CTRL_SRC1_ZERO   = 4;

    // Register fields are packed directly below the opcode: rd, then rs, then rt.
    function automatic int rd_hi(input int data_w, input int opc_w);
        return data_w - opc_w - 1;
    endfunction

    function automatic int rs_hi(input int data_w, input int opc_w, input int reg_aw);
        return data_w - opc_w - 1 - reg_aw;
    endfunction

    function automatic int rt_hi(input int data_w, input int opc_w, input int reg_aw);
        return data_w - opc_w - 1 - 2 * reg_aw;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with hardwired zero register, two operand ports plus a link port,
// and write-through so a same-cycle writeback is visible to the reader.
module id_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int LINK_REG = NUM_REGS - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] ra_idx,
    input  logic [REG_AW-1:0] rb_idx,
    output logic [DATA_W-1:0] ra_val,
    output logic [DATA_W-1:0] rb_val,
    output logic [DATA_W-1:0] link_val
);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic [REG_AW-1:0] port_idx [3];
    logic [DATA_W-1:0] port_val [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            regs_reg[wb_rd] <= wb_data;
        end
    end

    assign port_idx[0] = ra_idx;
    assign port_idx[1] = rb_idx;
    assign port_idx[2] = REG_AW'(LINK_REG);

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            port_val[p] = regs_reg[port_idx[p]];
            if (port_idx[p] == '0) begin
                port_val[p] = '0;
            end else if (wb_en && (wb_rd == port_idx[p])) begin
                port_val[p] = wb_data;
            end
        end
    end

    assign ra_val   = port_val[0];
    assign rb_val   = port_val[1];
    assign link_val = port_val[2];

endmodule

// File: rtl/id_stage_param.sv
// Instruction decode stage: field decode, immediate extension, forwarding, compare
// flags and branch/jump targets, all captured in the ID/EX pipeline register.
module id_stage_param
    import id_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_REGS   = 8,
    parameter int REG_AW     = $clog2(NUM_REGS),
    parameter int OPC_W      = 4,
    parameter int IMM_W      = 8,
    parameter int LINK_REG   = NUM_REGS - 1,
    parameter int SIGNED_CMP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] npc,
    input  logic [4:0]        ctrl,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              out_valid,
    output logic [REG_AW-1:0] ra,
    output logic [REG_AW-1:0] rb,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] br_target,
    output logic [DATA_W-1:0] j_target,
    output logic [DATA_W-1:0] ret_addr,
    output logic [DATA_W-1:0] pc_out,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    localparam int RD_HI = rd_hi(DATA_W, OPC_W);
    localparam int RS_HI = rs_hi(DATA_W, OPC_W, REG_AW);
    localparam int RT_HI = rt_hi(DATA_W, OPC_W, REG_AW);

    logic [REG_AW-1:0] rd_f, rs_f, rt_f;
    logic [REG_AW-1:0] ra_next, rb_next, rd_next;
    logic [IMM_W-1:0]  imm_f;
    logic [DATA_W-1:0] imm_next, a_next, b_next;
    logic [DATA_W-1:0] ra_val, rb_val, link_val;
    logic              gt_next, lt_next, eq_next;

    assign rd_f  = instruction[RD_HI -: REG_AW];
    assign rs_f  = instruction[RS_HI -: REG_AW];
    assign rt_f  = instruction[RT_HI -: REG_AW];
    assign imm_f = instruction[IMM_W-1:0];

    assign ra_next = ctrl[CTRL_SRC1_ZERO]   ? '0                 : rs_f;
    assign rb_next = ctrl[CTRL_SRC2_SEL]    ? rt_f               : rd_f;
    assign rd_next = ctrl[CTRL_REGDST_LINK] ? REG_AW'(LINK_REG)  : rd_f;

    // MSB placement is used for upper-immediate loads, so sign extension never applies there.
    always_comb begin
        imm_next = {{(DATA_W-IMM_W){1'b0}}, imm_f};
        if (ctrl[CTRL_EXT_PLACE]) begin
            imm_next = {imm_f, {(DATA_W-IMM_W){1'b0}}};
        end else if (ctrl[CTRL_EXT_OP]) begin
            imm_next = {{(DATA_W-IMM_W){imm_f[IMM_W-1]}}, imm_f};
        end
    end

    id_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_result),
        .ra_idx   (ra_next),
        .rb_idx   (rb_next),
        .ra_val   (ra_val),
        .rb_val   (rb_val),
        .link_val (link_val)
    );

    always_comb begin
        a_next = ra_val;
        case (fwd_a)
            FWD_ALU: a_next = alu_result;
            FWD_MEM: a_next = mem_result;
            FWD_WB:  a_next = wb_result;
            default: a_next = ra_val;
        endcase
        b_next = rb_val;
        case (fwd_b)
            FWD_ALU: b_next = alu_result;
            FWD_MEM: b_next = mem_result;
            FWD_WB:  b_next = wb_result;
            default: b_next = rb_val;
        endcase
    end

    always_comb begin
        eq_next = (a_next == b_next);
        if (SIGNED_CMP != 0) begin
            gt_next = $signed(a_next) > $signed(b_next);
            lt_next = $signed(a_next) < $signed(b_next);
        end else begin
            gt_next = a_next > b_next;
            lt_next = a_next < b_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            rd        <= '0;
            a         <= '0;
            b         <= '0;
            imm       <= '0;
            br_target <= '0;
            j_target  <= '0;
            ret_addr  <= '0;
            pc_out    <= '0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            rd        <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            ra        <= ra_next;
            rb        <= rb_next;
            rd        <= rd_next;
            a         <= a_next;
            b         <= b_next;
            imm       <= imm_next;
            br_target <= npc + imm_next;
            j_target  <= {npc[DATA_W-1 -: OPC_W], instruction[DATA_W-OPC_W-1:0]};
            ret_addr  <= link_val;
            pc_out    <= npc;
            gt        <= gt_next;
            lt        <= lt_next;
            eq        <= eq_next;
        end
    end

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for the decode stage; a second instance with unsigned compare
// shares all inputs so both compare modes are exercised by the same vectors.
module tb_id_stage_param;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] instruction = '0;
    logic [DATA_W-1:0] npc = '0;
    logic [4:0]        ctrl = '0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        fwd_a = '0;
    logic [1:0]        fwd_b = '0;
    logic [DATA_W-1:0] alu_result = '0;
    logic [DATA_W-1:0] mem_result = '0;
    logic [DATA_W-1:0] wb_result = '0;
    logic              wb_en = 1'b0;
    logic [REG_AW-1:0] wb_rd = '0;

    logic              out_valid, gt, lt, eq;
    logic [REG_AW-1:0] ra, rb, rd;
    logic [DATA_W-1:0] a, b, imm, br_target, j_target, ret_addr, pc_out;

    logic              u_out_valid, u_gt, u_lt, u_eq;
    logic [REG_AW-1:0] u_ra, u_rb, u_rd;
    logic [DATA_W-1:0] u_a, u_b, u_imm, u_br_target, u_j_target, u_ret_addr, u_pc_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_stage_param dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .npc(npc), .ctrl(ctrl), .stall(stall), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .alu_result(alu_result),
        .mem_result(mem_result), .wb_result(wb_result), .wb_en(wb_en), .wb_rd(wb_rd),
        .out_valid(out_valid), .ra(ra), .rb(rb), .rd(rd), .a(a), .b(b), .imm(imm),
        .br_target(br_target), .j_target(j_target), .ret_addr(ret_addr),
        .pc_out(pc_out), .gt(gt), .lt(lt), .eq(eq)
    );

    id_stage_param #(.SIGNED_CMP(0)) dut_uns (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .npc(npc), .ctrl(ctrl), .stall(stall), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .alu_result(alu_result),
        .mem_result(mem_result), .wb_result(wb_result), .wb_en(wb_en), .wb_rd(wb_rd),
        .out_valid(u_out_valid), .ra(u_ra), .rb(u_rb), .rd(u_rd), .a(u_a), .b(u_b),
        .imm(u_imm), .br_target(u_br_target), .j_target(u_j_target),
        .ret_addr(u_ret_addr), .pc_out(u_pc_out), .gt(u_gt), .lt(u_lt), .eq(u_eq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles while a write to r3 is attempted
        reset = 1'b1; wb_en = 1'b1; wb_rd = 3'd3; wb_result = 16'hBEEF;
        instruction = 16'h0283; npc = 16'h0010; in_valid = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_a", 32'(a), 32'h0);
        check("rst_imm", 32'(imm), 32'h0);
        check("rst_rd", 32'(rd), 32'h0);
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_br", 32'(br_target), 32'h0);

        reset = 1'b0; wb_en = 1'b0; instruction = 16'h00C0; npc = 16'h0001;
        tick();
        check("r3_after_rst", 32'(a), 32'h0);
        check("r3_ra", 32'(ra), 32'h3);

        // Write r2, decoding a bubble (in_valid=0) at the same time
        wb_en = 1'b1; wb_rd = 3'd2; wb_result = 16'h0008;
        in_valid = 1'b0; instruction = 16'h0000; npc = 16'h0005;
        tick();
        check("bubble_valid", 32'(out_valid), 32'h0);
        check("bubble_pc", 32'(pc_out), 32'h0005);

        wb_en = 1'b0; in_valid = 1'b1; instruction = 16'h0283; npc = 16'h0010;
        tick();
        check("wr_a", 32'(a), 32'h0008);
        check("wr_imm", 32'(imm), 32'h0083);
        check("wr_br", 32'(br_target), 32'h0093);
        check("wr_valid", 32'(out_valid), 32'h1);
        check("wr_ra", 32'(ra), 32'h2);
        check("wr_rb", 32'(rb), 32'h1);
        check("wr_rd", 32'(rd), 32'h1);
        check("wr_j", 32'(j_target), 32'h0283);

        // Same-cycle write-through into the rs port
        wb_en = 1'b1; wb_rd = 3'd4; wb_result = 16'h1234; instruction = 16'h0100;
        tick();
        check("byp_a", 32'(a), 32'h1234);

        wb_rd = 3'd0; wb_result = 16'h5555; instruction = 16'h0000;
        tick();
        check("r0_a", 32'(a), 32'h0);
        check("r0_b", 32'(b), 32'h0);

        wb_en = 1'b0; instruction = 16'h0100;
        tick();
        check("r4_stored", 32'(a), 32'h1234);

        // Forwarding with compare in both signed and unsigned modes
        fwd_a = 2'd1; fwd_b = 2'd2; alu_result = 16'hFFFE; mem_result = 16'h0001;
        instruction = 16'h0600; npc = 16'h0020;
        tick();
        check("fwd_a", 32'(a), 32'hFFFE);
        check("fwd_b", 32'(b), 32'h0001);
        check("s_lt", 32'(lt), 32'h1);
        check("s_gt", 32'(gt), 32'h0);
        check("s_eq", 32'(eq), 32'h0);
        check("u_gt", 32'(u_gt), 32'h1);
        check("u_lt", 32'(u_lt), 32'h0);
        check("fwd_rd", 32'(rd), 32'h3);

        // Stall two cycles while inputs change and r5 is written underneath
        stall = 1'b1; fwd_a = 2'd0; fwd_b = 2'd0; instruction = 16'h0E00; npc = 16'h0099;
        wb_en = 1'b1; wb_rd = 3'd5; wb_result = 16'h7777;
        tick(); tick();
        check("stl_a", 32'(a), 32'hFFFE);
        check("stl_rd", 32'(rd), 32'h3);
        check("stl_pc", 32'(pc_out), 32'h0020);
        check("stl_lt", 32'(lt), 32'h1);
        check("stl_valid", 32'(out_valid), 32'h1);

        flush = 1'b1; wb_en = 1'b0;
        tick();
        check("fl_valid", 32'(out_valid), 32'h0);
        check("fl_rd", 32'(rd), 32'h0);
        check("fl_pc", 32'(pc_out), 32'h0020);
        check("fl_a", 32'(a), 32'hFFFE);

        stall = 1'b0; flush = 1'b0; instruction = 16'h0140; npc = 16'h0030;
        tick();
        check("r5_written", 32'(a), 32'h7777);

        // Link destination with sign-extended immediate; r7 written the same cycle
        wb_en = 1'b1; wb_rd = 3'd7; wb_result = 16'hABCD;
        ctrl = 5'b00110; instruction = 16'h0080; npc = 16'h0100;
        tick();
        check("lnk_rd", 32'(rd), 32'h7);
        check("lnk_imm", 32'(imm), 32'hFF80);
        check("lnk_br_wrap", 32'(br_target), 32'h0080);
        check("lnk_ret", 32'(ret_addr), 32'hABCD);
        check("lnk_a", 32'(a), 32'h0008);

        wb_en = 1'b0; ctrl = 5'b00011; instruction = 16'h0012;
        tick();
        check("hi_imm", 32'(imm), 32'h1200);
        check("hi_rd", 32'(rd), 32'h0);
        check("hi_ret", 32'(ret_addr), 32'hABCD);

        // Reset while stalled clears both pipeline and register file
        stall = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0; ctrl = 5'b00000;
        check("rst_stl_valid", 32'(out_valid), 32'h0);
        check("rst_stl_ret", 32'(ret_addr), 32'h0);
        tick();
        check("rst_r7_clear", 32'(ret_addr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
